// File: rtl/key_pkg.sv
// Shared definitions for the front-panel key path: FSM state encoding and
// millisecond-to-cycle conversion.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } key_state_t;

  function automatic longint unsigned ms_to_cyc(input longint unsigned ms,
                                                input longint unsigned freq);
    return ms * 64'd1000 * freq;
  endfunction

endpackage

// File: rtl/key_timer.sv
// Saturating up-counter with synchronous clear and an equality compare
// against a runtime limit; tc_eq is combinational from the count.
module key_timer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [N-1:0] limit,
  output logic [N-1:0] count,
  output logic         tc_eq
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + N'(1);
    end
  end

  assign tc_eq = (count == limit);

endmodule

// File: rtl/key_event_decoder.sv
// Turns a debounced key level into short / double / long / repeat pulses.
// All outputs registered; each pulse appears the cycle after its deciding edge.
module key_event_decoder
  import key_pkg::*;
#(
  parameter int unsigned N         = 32,
  parameter int unsigned FREQ      = 100,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned DBL_MS    = 300,
  parameter int unsigned REPEAT_MS = 200,
  parameter bit          DBL_EN    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_held,
  output logic evt_short,
  output logic evt_double,
  output logic evt_long,
  output logic evt_repeat
);

  localparam longint unsigned LONG_CYC = ms_to_cyc(64'(LONG_MS), 64'(FREQ));
  localparam longint unsigned DBL_CYC  = ms_to_cyc(64'(DBL_MS), 64'(FREQ));
  localparam longint unsigned REP_CYC  = ms_to_cyc(64'(REPEAT_MS), 64'(FREQ));
  localparam longint unsigned TMAX     = 64'd1 << N;

  localparam logic [N-1:0] LONG_LIM = N'(LONG_CYC - 64'd1);
  localparam logic [N-1:0] DBL_LIM  = N'(DBL_CYC - 64'd1);
  localparam logic [N-1:0] REP_LIM  = N'(REP_CYC - 64'd1);

  if (LONG_CYC < 64'd2 || LONG_CYC >= TMAX) begin : g_bad_long
    $error("key_event_decoder: LONG_CYC out of range");
  end
  if (DBL_CYC < 64'd2 || DBL_CYC >= TMAX) begin : g_bad_dbl
    $error("key_event_decoder: DBL_CYC out of range");
  end
  if (REP_CYC < 64'd2 || REP_CYC >= TMAX) begin : g_bad_rep
    $error("key_event_decoder: REP_CYC out of range");
  end

  key_state_t   state, state_next;
  logic         key_d;
  logic         press, release_;
  logic         short_nxt, double_nxt, long_nxt, repeat_nxt;
  logic         timer_clr, tc_eq;
  logic [N-1:0] limit, count;

  assign press    = key_d & ~key_in;
  assign release_ = ~key_d & key_in;

  always_comb begin
    limit = '0;
    case (state)
      PRESS1:  limit = LONG_LIM;
      WAIT2:   limit = DBL_LIM;
      LONG:    limit = REP_LIM;
      default: limit = '0;
    endcase
  end

  // A repeat restarts the period without leaving LONG, so it clears too.
  assign timer_clr = (state_next != state) | repeat_nxt;

  key_timer #(.N(N)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (timer_clr),
    .limit (limit),
    .count (count),
    .tc_eq (tc_eq)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (press) state_next = PRESS1;
      PRESS1: begin
        if (release_)   state_next = DBL_EN ? WAIT2 : IDLE;
        else if (tc_eq) state_next = LONG;
      end
      WAIT2: begin
        if (press)      state_next = PRESS2;
        else if (tc_eq) state_next = IDLE;
      end
      PRESS2:  if (release_) state_next = IDLE;
      LONG:    if (release_) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    short_nxt  = ((state == PRESS1) && release_ && !DBL_EN) ||
                 ((state == WAIT2) && !press && tc_eq);
    double_nxt = (state == PRESS2) && release_;
    long_nxt   = (state == PRESS1) && !release_ && tc_eq;
    repeat_nxt = (state == LONG) && !release_ && tc_eq;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_d      <= 1'b1;
      key_held   <= 1'b0;
      evt_short  <= 1'b0;
      evt_double <= 1'b0;
      evt_long   <= 1'b0;
      evt_repeat <= 1'b0;
    end else begin
      key_d      <= key_in;
      key_held   <= ~key_in;
      evt_short  <= short_nxt;
      evt_double <= double_nxt;
      evt_long   <= long_nxt;
      evt_repeat <= repeat_nxt;
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Randomised + directed bench for key_event_decoder with a timestamp-based
// reference model feeding per-instance expected-event queues.
module tb_key_event_decoder;

  localparam int LONG = 4000;
  localparam int DBL  = 1000;
  localparam int REP  = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_in = 1'b1;
  logic held_a, s_a, d_a, l_a, r_a;
  logic held_b, s_b, d_b, l_b, r_b;

  always #5 clk = ~clk;

  key_event_decoder #(.N(32), .FREQ(1), .LONG_MS(4), .DBL_MS(1), .REPEAT_MS(2), .DBL_EN(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .key_in(key_in), .key_held(held_a),
    .evt_short(s_a), .evt_double(d_a), .evt_long(l_a), .evt_repeat(r_a)
  );

  key_event_decoder #(.N(32), .FREQ(1), .LONG_MS(4), .DBL_MS(1), .REPEAT_MS(2), .DBL_EN(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .key_in(key_in), .key_held(held_b),
    .evt_short(s_b), .evt_double(d_b), .evt_long(l_b), .evt_repeat(r_b)
  );

  typedef struct {
    int c;
    int ev;
  } exp_t;

  int   nchk = 0;
  int   nerr = 0;
  int   cyc  = 0;
  exp_t q0[$];
  exp_t q1[$];

  // Model state: act = first press held (pt = press cycle), sec = second
  // press held, pend = released and waiting for a second press (rt = release cycle).
  bit   act[2], sec[2], pend[2];
  int   pt[2], rt[2];
  bit   kd = 1'b1;
  bit   exp_held = 1'b0;
  bit   m_pr, m_rl;

  task automatic push(input int i, input int c, input int ev);
    exp_t e;
    e.c  = c;
    e.ev = ev;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // ev codes: 1 short, 2 double, 3 long, 4 repeat
  task automatic step(input int i, input bit pr, input bit rl, input bit dbl_en, input int c);
    int h;
    if (act[i]) begin
      h = c - pt[i];
      if (rl) begin
        act[i] = 1'b0;
        if (h <= LONG) begin
          if (dbl_en) begin pend[i] = 1'b1; rt[i] = c; end
          else push(i, c, 1);
        end
      end else if (h == LONG) begin
        push(i, c, 3);
      end else if (h > LONG && ((h - LONG) % REP) == 0) begin
        push(i, c, 4);
      end
    end else if (sec[i]) begin
      if (rl) begin sec[i] = 1'b0; push(i, c, 2); end
    end else if (pend[i]) begin
      if (pr) begin
        pend[i] = 1'b0;
        sec[i]  = 1'b1;
      end else if (c - rt[i] == DBL) begin
        pend[i] = 1'b0;
        push(i, c, 1);
      end
    end else if (pr) begin
      act[i] = 1'b1;
      pt[i]  = c;
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        act[i] = 1'b0; sec[i] = 1'b0; pend[i] = 1'b0;
      end
      kd = 1'b1;
      exp_held = 1'b0;
    end else begin
      m_pr = kd & ~key_in;
      m_rl = ~kd & key_in;
      step(0, m_pr, m_rl, 1'b1, cyc);
      step(1, m_pr, m_rl, 1'b0, cyc);
      kd = key_in;
      exp_held = ~key_in;
    end
  end

  task automatic check_inst(input int i, input logic h, input logic s, input logic d,
                            input logic l, input logic r);
    int   n;
    int   ev;
    exp_t e;
    nchk++;
    if (h !== exp_held) begin
      nerr++;
      $display("FAIL key_held[%0d] cycle %0d: got %b expected %b", i, cyc, h, exp_held);
    end
    // Drop expected events whose cycle has passed without a pulse.
    while ((i == 0 ? q0.size() : q1.size()) > 0) begin
      e = (i == 0) ? q0[0] : q1[0];
      if (e.c >= cyc) break;
      if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      nchk++;
      nerr++;
      $display("FAIL missed_event[%0d]: got none expected ev=%0d at cycle %0d", i, e.ev, e.c);
    end
    n = int'(s) + int'(d) + int'(l) + int'(r);
    if (n > 1) begin
      nchk++;
      nerr++;
      $display("FAIL onehot[%0d] cycle %0d: got %0d pulses expected 1", i, cyc, n);
    end
    if (n >= 1) begin
      ev = s ? 1 : d ? 2 : l ? 3 : 4;
      nchk++;
      if ((i == 0 ? q0.size() : q1.size()) == 0) begin
        nerr++;
        $display("FAIL unexpected_event[%0d] cycle %0d: got ev=%0d expected none", i, cyc, ev);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        if (e.c != cyc || e.ev != ev) begin
          nerr++;
          $display("FAIL event[%0d]: got ev=%0d at cycle %0d expected ev=%0d at cycle %0d",
                   i, ev, cyc, e.ev, e.c);
        end
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    check_inst(0, held_a, s_a, d_a, l_a, r_a);
    check_inst(1, held_b, s_b, d_b, l_b, r_b);
  end

  task automatic check_zero(input string name);
    logic [9:0] v;
    v = {held_a, s_a, d_a, l_a, r_a, held_b, s_b, d_b, l_b, r_b};
    nchk++;
    if (v !== 10'b0) begin
      nerr++;
      $display("FAIL %s: got outputs %b expected all 0", name, v);
    end
  endtask

  task automatic hold(input int n);
    key_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    key_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic rst_pulse(input int n);
    rst = 1'b1;
    #1;
    check_zero("reset_immediate");
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;
    idle(10);
    // short press, double click, long hold with repeats
    hold(100); idle(1500);
    hold(100); idle(200); hold(100); idle(1500);
    hold(9000); idle(1500);
    // release on the long boundary: last cycle before, first cycle after
    hold(4000); idle(1500);
    hold(4001); idle(1500);
    // quick successive presses
    hold(50); idle(150); hold(50); idle(1500);
    // second press on the double-click window edge and one past it
    hold(20); idle(1000); hold(20); idle(1500);
    hold(20); idle(1001); hold(20); idle(1500);
    // reset during WAIT2
    hold(100); idle(500); rst_pulse(3); idle(1500);
    // reset during LONG with the key held through reset
    hold(5000); rst_pulse(3); hold(5000); idle(1500);
    // random press/gap mix
    repeat (20) begin
      hold(int'($urandom_range(1, ($urandom_range(0, 7) == 0) ? 6000 : 400)));
      idle(int'($urandom_range(1, 1200)));
    end
    idle(1500);
    nchk++;
    if (q0.size() != 0) begin
      nerr++;
      $display("FAIL leftover_a: got %0d pending expected 0", q0.size());
    end
    nchk++;
    if (q1.size() != 0) begin
      nerr++;
      $display("FAIL leftover_b: got %0d pending expected 0", q1.size());
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
